// File: rtl/n_bit_comparator.sv
// Registered N-bit magnitude comparator with per-transaction signed/unsigned mode.
// A log-depth compare tree feeds four output flops; valid-out marks fresh flags.
module n_bit_comparator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         is_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  localparam int L = $clog2(N);
  localparam int P = 1 << L;

  logic [N-1:0] aAdj;
  logic [N-1:0] bAdj;
  logic         gt_d;
  logic         lt_d;
  logic         eq_d;
  logic         out_valid_q;
  logic         gt_q;
  logic         lt_q;
  logic         eq_q;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    aAdj = a;
    bAdj = b;
    aAdj[N-1] = a[N-1] ^ is_signed;
    bAdj[N-1] = b[N-1] ^ is_signed;
  end

  for (genvar l = 0; l <= L; l++) begin : lvl
    logic [(P >> l)-1:0] g;
    logic [(P >> l)-1:0] e;
    if (l == 0) begin : leaf
      for (genvar i = 0; i < P; i++) begin : bitCmp
        if (i < N) begin : real_bit
          assign g[i] = aAdj[i] & ~bAdj[i];
          assign e[i] = ~(aAdj[i] ^ bAdj[i]);
        end else begin : pad_bit
          assign g[i] = 1'b0;
          assign e[i] = 1'b1;
        end
      end
    end else begin : node
      // The upper half decides unless it is equal, then the lower half decides.
      for (genvar j = 0; j < (P >> l); j++) begin : merge
        assign g[j] = lvl[l-1].g[2*j+1] | (lvl[l-1].e[2*j+1] & lvl[l-1].g[2*j]);
        assign e[j] = lvl[l-1].e[2*j+1] & lvl[l-1].e[2*j];
      end
    end
  end

  assign gt_d = lvl[L].g[0];
  assign eq_d = lvl[L].e[0];
  assign lt_d = ~(gt_d | eq_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        gt_q <= gt_d;
        lt_q <= lt_d;
        eq_q <= eq_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;

endmodule

// File: tb/tb_n_bit_comparator.sv
// Directed and randomized bench for n_bit_comparator at N=8, N=1 and N=64.
module tb_n_bit_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        inValid8, isSigned8, outValid8, gt8, lt8, eq8;
  logic [7:0]  a8, b8;
  logic        inValid1, isSigned1, outValid1, gt1, lt1, eq1;
  logic [0:0]  a1, b1;
  logic        inValid64, isSigned64, outValid64, gt64, lt64, eq64;
  logic [63:0] a64, b64;

  always #5 clk = ~clk;

  n_bit_comparator #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .is_signed(isSigned8),
    .a(a8), .b(b8), .out_valid(outValid8), .gt(gt8), .lt(lt8), .eq(eq8)
  );

  n_bit_comparator #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .is_signed(isSigned1),
    .a(a1), .b(b1), .out_valid(outValid1), .gt(gt1), .lt(lt1), .eq(eq1)
  );

  n_bit_comparator #(.N(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid64), .is_signed(isSigned64),
    .a(a64), .b(b64), .out_valid(outValid64), .gt(gt64), .lt(lt64), .eq(eq64)
  );

  function automatic logic [2:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic g, l;
    g = s ? ($signed(x) > $signed(y)) : (x > y);
    l = s ? ($signed(x) < $signed(y)) : (x < y);
    return {g, l, x == y};
  endfunction

  function automatic logic [2:0] ref1(input logic s, input logic [0:0] x, input logic [0:0] y);
    logic g, l;
    g = s ? ($signed(x) > $signed(y)) : (x > y);
    l = s ? ($signed(x) < $signed(y)) : (x < y);
    return {g, l, x == y};
  endfunction

  function automatic logic [2:0] ref64(input logic s, input logic [63:0] x, input logic [63:0] y);
    logic g, l;
    g = s ? ($signed(x) > $signed(y)) : (x > y);
    l = s ? ($signed(x) < $signed(y)) : (x < y);
    return {g, l, x == y};
  endfunction

  task automatic applyStimulus(input logic s, input logic [7:0] x, input logic [7:0] y);
    inValid8  = 1'b1;
    isSigned8 = s;
    a8        = x;
    b8        = y;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd5, 8'd3);
    repeat (2) @(negedge clk);
    checks++;
    if ({outValid8, gt8, lt8, eq8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset8: got %b want 0000", {outValid8, gt8, lt8, eq8});
    end
    checks++;
    if ({outValid1, gt1, lt1, eq1, outValid64, gt64, lt64, eq64} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset1_64: got %b want 00000000",
               {outValid1, gt1, lt1, eq1, outValid64, gt64, lt64, eq64});
    end
    inValid8 = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [7:0] xs [5] = '{8'd5, 8'd3, 8'd10, 8'd255, 8'd0};
    logic [7:0] ys [5] = '{8'd3, 8'd5, 8'd10, 8'd0, 8'd255};
    logic [2:0] ex [5] = '{GT, LT, EQ, GT, LT};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, xs[i], ys[i]);
      @(negedge clk);
      inValid8 = 1'b0;
      checks++;
      if ({outValid8, gt8, lt8, eq8} !== {1'b1, ex[i]}) begin
        errors++;
        $display("[TB] FAIL unsigned[%0d] a=%0d b=%0d: got %b want %b",
                 i, xs[i], ys[i], {outValid8, gt8, lt8, eq8}, {1'b1, ex[i]});
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0] xs [4] = '{8'hFF, 8'h80, 8'h7F, 8'hFE};
    logic [7:0] ys [4] = '{8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [2:0] ex [4] = '{LT, LT, GT, LT};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, xs[i], ys[i]);
      @(negedge clk);
      inValid8 = 1'b0;
      checks++;
      if ({outValid8, gt8, lt8, eq8} !== {1'b1, ex[i]}) begin
        errors++;
        $display("[TB] FAIL signed[%0d] a=%h b=%h: got %b want %b",
                 i, xs[i], ys[i], {outValid8, gt8, lt8, eq8}, {1'b1, ex[i]});
      end
    end
  endtask

  task automatic test_same_operands();
    logic [2:0] ex [2] = '{GT, LT};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(i[0], 8'h80, 8'h01);
      @(negedge clk);
      inValid8 = 1'b0;
      checks++;
      if ({outValid8, gt8, lt8, eq8} !== {1'b1, ex[i]}) begin
        errors++;
        $display("[TB] FAIL mode[%0d] a=80 b=01: got %b want %b",
                 i, {outValid8, gt8, lt8, eq8}, {1'b1, ex[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       ss [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] xs [3] = '{8'd5, 8'hFF, 8'd9};
    logic [7:0] ys [3] = '{8'd3, 8'h01, 8'd9};
    logic [2:0] ex [3] = '{GT, LT, EQ};
    @(negedge clk);
    applyStimulus(ss[0], xs[0], ys[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) applyStimulus(ss[i+1], xs[i+1], ys[i+1]);
      else inValid8 = 1'b0;
      checks++;
      if ({outValid8, gt8, lt8, eq8} !== {1'b1, ex[i]}) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: got %b want %b", i, {outValid8, gt8, lt8, eq8}, {1'b1, ex[i]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({outValid8, gt8, lt8, eq8} !== {1'b0, EQ}) begin
        errors++;
        $display("[TB] FAIL gap[%0d]: got %b want %b", i, {outValid8, gt8, lt8, eq8}, {1'b0, EQ});
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    applyStimulus(1'b0, 8'd1, 8'd2);
    @(negedge clk);
    checks++;
    if ({outValid8, gt8, lt8, eq8} !== {1'b1, LT}) begin
      errors++;
      $display("[TB] FAIL pre_reset: got %b want %b", {outValid8, gt8, lt8, eq8}, {1'b1, LT});
    end
    applyStimulus(1'b0, 8'd7, 8'd7);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({outValid8, gt8, lt8, eq8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b want 0000", {outValid8, gt8, lt8, eq8});
    end
    rst_n    = 1'b1;
    inValid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({outValid8, gt8, lt8, eq8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL post_release_idle: got %b want 0000", {outValid8, gt8, lt8, eq8});
    end
    applyStimulus(1'b0, 8'd200, 8'd100);
    @(negedge clk);
    inValid8 = 1'b0;
    checks++;
    if ({outValid8, gt8, lt8, eq8} !== {1'b1, GT}) begin
      errors++;
      $display("[TB] FAIL first_after_reset: got %b want %b", {outValid8, gt8, lt8, eq8}, {1'b1, GT});
    end
  endtask

  task automatic test_random();
    logic       ev8 = 1'b0, ev1 = 1'b0, ev64 = 1'b0;
    logic [2:0] ef8 = 3'b000, ef1 = 3'b000, ef64 = 3'b000;
    @(negedge clk);
    rst_n = 1'b0;
    inValid8 = 1'b0; inValid1 = 1'b0; inValid64 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 10000; i++) begin
      if (i > 0) begin
        checks++;
        if ({outValid8, gt8, lt8, eq8} !== {ev8, ef8}) begin
          errors++;
          $display("[TB] FAIL rand8[%0d]: got %b want %b", i, {outValid8, gt8, lt8, eq8}, {ev8, ef8});
        end
        checks++;
        if ({outValid1, gt1, lt1, eq1} !== {ev1, ef1}) begin
          errors++;
          $display("[TB] FAIL rand1[%0d]: got %b want %b", i, {outValid1, gt1, lt1, eq1}, {ev1, ef1});
        end
        checks++;
        if ({outValid64, gt64, lt64, eq64} !== {ev64, ef64}) begin
          errors++;
          $display("[TB] FAIL rand64[%0d]: got %b want %b", i, {outValid64, gt64, lt64, eq64}, {ev64, ef64});
        end
        if (outValid8 || outValid1 || outValid64) begin
          checks++;
          if ((outValid8 && !$onehot({gt8, lt8, eq8})) || (outValid1 && !$onehot({gt1, lt1, eq1})) ||
              (outValid64 && !$onehot({gt64, lt64, eq64}))) begin
            errors++;
            $display("[TB] FAIL onehot[%0d]: got %b %b %b want one-hot",
                     i, {gt8, lt8, eq8}, {gt1, lt1, eq1}, {gt64, lt64, eq64});
          end
        end
      end
      if (i < 10000) begin
        inValid8   = ($urandom_range(0, 7) != 0);
        isSigned8  = 1'($urandom);
        a8         = 8'($urandom);
        b8         = ($urandom_range(0, 7) == 0) ? a8 : 8'($urandom);
        inValid1   = ($urandom_range(0, 7) != 0);
        isSigned1  = 1'($urandom);
        a1         = 1'($urandom);
        b1         = 1'($urandom);
        inValid64  = ($urandom_range(0, 7) != 0);
        isSigned64 = 1'($urandom);
        a64        = {$urandom, $urandom};
        b64        = ($urandom_range(0, 7) == 0) ? a64 : {$urandom, $urandom};
        ev8  = inValid8;
        ev1  = inValid1;
        ev64 = inValid64;
        if (inValid8)  ef8  = ref8(isSigned8, a8, b8);
        if (inValid1)  ef1  = ref1(isSigned1, a1, b1);
        if (inValid64) ef64 = ref64(isSigned64, a64, b64);
        @(negedge clk);
      end
    end
    inValid8 = 1'b0; inValid1 = 1'b0; inValid64 = 1'b0;
  endtask

  task automatic test_n1_boundary();
    @(negedge clk);
    inValid1 = 1'b1; isSigned1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    isSigned1 = 1'b1;
    checks++;
    if ({outValid1, gt1, lt1, eq1} !== {1'b1, GT}) begin
      errors++;
      $display("[TB] FAIL n1_unsigned: got %b want %b", {outValid1, gt1, lt1, eq1}, {1'b1, GT});
    end
    @(negedge clk);
    inValid1 = 1'b0;
    checks++;
    if ({outValid1, gt1, lt1, eq1} !== {1'b1, LT}) begin
      errors++;
      $display("[TB] FAIL n1_signed: got %b want %b", {outValid1, gt1, lt1, eq1}, {1'b1, LT});
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    inValid8 = 1'b0;  isSigned8 = 1'b0;  a8 = '0;  b8 = '0;
    inValid1 = 1'b0;  isSigned1 = 1'b0;  a1 = '0;  b1 = '0;
    inValid64 = 1'b0; isSigned64 = 1'b0; a64 = '0; b64 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_same_operands();
    test_back_to_back();
    test_reset_midstream();
    test_n1_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_bit_comparator.md
# n_bit_comparator

Registered N-bit magnitude comparator for datapath compare and branch decisions. It compares operands `a` and `b` as unsigned or two's-complement values, selected per transaction. It produces mutually exclusive one-hot flags `gt`, `lt` and `eq` one clock after a valid input. A valid-in/valid-out qualifier lets downstream logic sample the flags only when they are fresh.

## Interface
- `N`, default 8: operand width in bits; legal range 1..64.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  high = `a`, `b` and `is_signed` are sampled this edge.
- `is_signed`  input  1  0 = unsigned compare, 1 = two's-complement compare.
- `a`  input  N  left operand.
- `b`  input  N  right operand.
- `out_valid`  output  1  high for one cycle per accepted input; flags are fresh.
- `gt`  output  1  registered: `a` > `b`.
- `lt`  output  1  registered: `a` < `b`.
- `eq`  output  1  registered: `a` == `b`.

## Operation
- Every rising `clk` edge with `rst_n`=0 clears all of the following to 0: `out_valid`, `gt`, `lt` and `eq`. Reset dominates `in_valid`.
- Every rising `clk` edge with `rst_n`=1 and `in_valid`=1 does the following:
  - Compares `a` and `b` over the full N bits.
  - Registers the three flags.
  - Sets `out_valid`=1.
- Unsigned mode (`is_signed`=0):
  - Compares operands as 0..2^N-1.
  - Flags: `gt` = (a>b), `lt` = (a<b), `eq` = (a==b).
- Signed mode (`is_signed`=1):
  - Bit N-1 is the sign bit and operands range -2^(N-1)..2^(N-1)-1.
  - Operands with differing sign bits: the operand with the sign bit set is the smaller.
  - Operands with equal sign bits: use the unsigned compare of the full word.
- `eq` does not depend on `is_signed`.
- Whenever `out_valid`=1, exactly one of `gt`, `lt`, `eq` is 1.
- Rising edge with `rst_n`=1 and `in_valid`=0:
  - `out_valid` goes to 0.
  - `gt`, `lt` and `eq` hold their last values.
  - Consumers must ignore the flags while `out_valid`=0.
- N=1:
  - Unsigned: 1 > 0.
  - Signed: 1 is -1, so 1 < 0.
- The comparison is purely combinational ahead of the output registers. There is no internal state beyond the four output flops.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k and remain stable until edge k+1.
- Throughput is 1 compare per cycle. Back-to-back `in_valid` gives continuous `out_valid` with a new result every cycle.
- No backpressure; the block is always ready.
- Reset:
  - Asserting `rst_n`=0 in the same cycle as `in_valid`=1 discards that transaction; outputs are 0 after the edge.
  - Releasing reset: the first edge with `rst_n`=1 and `in_valid`=1 produces a valid result on the next cycle.
- Outputs are all-zero after reset until the first accepted input. That all-zero state is the only one where none of `gt`, `lt`, `eq` is set.
- The combinational compare path must close timing at the target clock for N=64.

## Test plan
- Unsigned directed cases with N=8 and `is_signed`=0, each giving `out_valid`=1 one cycle later:
  - a=5, b=3 -> gt=1 lt=0 eq=0.
  - a=3, b=5 -> lt=1.
  - a=10, b=10 -> eq=1.
  - a=255, b=0 -> gt=1.
  - a=0, b=255 -> lt=1.
- Signed directed cases with `is_signed`=1:
  - a=8'hFF (-1), b=8'h01 -> lt=1.
  - a=8'h80 (-128), b=8'h7F -> lt=1.
  - a=8'h7F, b=8'h80 -> gt=1.
  - a=8'hFE, b=8'hFF -> lt=1.
- Same operands in both modes: a=8'h80, b=8'h01 -> gt=1 with `is_signed`=0, lt=1 with `is_signed`=1.
- Back-to-back and gap: valid for 3 cycles, then idle for 2 cycles.
  - `out_valid` is high for exactly 3 cycles, each with the correct flags.
  - `out_valid` then falls, and the flags hold the third result.
- Reset mid-stream:
  - Pull `rst_n` low during streaming -> the next cycle shows all outputs 0, and the input sampled at that edge is dropped.
  - After release, the first valid input yields its result one cycle later.
- Randomized: 10k random a, b and `is_signed` values checked against a reference compare. Check one-hot flags whenever `out_valid`=1. Repeat with N=1 and N=64.
